// File: rtl/hazard_ctrl.sv
// Pipeline sequencing for the 5-stage RV32I core: load-use bubbles, redirect
// squashes, EX operand forwarding, halt drain/freeze and saturating debug counters.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_halt,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, HALT_DRAIN, HALTED} state_t;

  state_t     state, state_nxt;
  logic [1:0] drain_cnt;
  logic       lu;
  logic       stall_evt;
  logic       flush_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // MEM result is younger than WB, so it wins; x0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs))
      fwd_sel = 2'b10;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs))
      fwd_sel = 2'b01;
    else
      fwd_sel = 2'b00;
  endfunction

  assign lu = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
               (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == HALT_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:        if (!ex_redirect && !lu && id_halt) state_nxt = HALT_DRAIN;
      HALT_DRAIN: if (drain_cnt == 2'd2) state_nxt = HALTED;
      HALTED:     state_nxt = HALTED;
      default:    state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    stall_evt  = 1'b0;
    flush_evt  = 1'b0;
    case (state)
      RUN: begin
        if (ex_redirect) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          flush_evt  = 1'b1;
        end else if (lu) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          stall_evt  = 1'b1;
        end else if (id_halt) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
        end
      end
      HALT_DRAIN: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b1;
      end
      HALTED: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      default: ;
    endcase
    // Reset overrides asynchronously, before the state register has been clocked.
    if (rst) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      stall_evt  = 1'b0;
      flush_evt  = 1'b0;
    end
  end

  assign fwd_a  = rst ? 2'b00 : fwd_sel(ex_rs1);
  assign fwd_b  = rst ? 2'b00 : fwd_sel(ex_rs2);
  assign halted = (state == HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt) stall_cnt <= sat_inc(stall_cnt);
      if (flush_evt) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with an abstract reference model checked
// every falling edge, plus hand-computed literal expectations.
module tb_hazard_ctrl;

  localparam int CW   = 4;
  localparam int MAXC = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_uses_rs1, id_uses_rs2, id_halt, ex_mem_read, ex_redirect;
  logic          mem_reg_write, wb_reg_write;
  logic          pc_write, ifid_write, ifid_flush, idex_flush, halted;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: phase 0 = running, 1..3 = drain cycle number, 4 = frozen.
  int phase   = 0;
  int m_stall = 0;
  int m_flush = 0;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_halt(id_halt),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_lu();
    bit hit1, hit2;
    hit1 = id_uses_rs1 && (id_rs1 == ex_rd);
    hit2 = id_uses_rs2 && (id_rs2 == ex_rd);
    return ex_mem_read && (ex_rd != 0) && (hit1 || hit2);
  endfunction

  function automatic int model_fwd(input logic [4:0] rs);
    if (rst || rs == 0) return 0;
    if (mem_reg_write && mem_rd == rs) return 2;
    if (wb_reg_write && wb_rd == rs) return 1;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   <= 0;
      m_stall <= 0;
      m_flush <= 0;
    end else if (phase == 0) begin
      if (ex_redirect) m_flush <= (m_flush + 1 > MAXC) ? MAXC : m_flush + 1;
      else if (model_lu()) m_stall <= (m_stall + 1 > MAXC) ? MAXC : m_stall + 1;
      else if (id_halt) phase <= 1;
    end else if (phase < 4) begin
      phase <= phase + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int e_pw, e_iw, e_if, e_xf, e_h;
      e_h = 0;
      if (rst) begin
        e_pw = 1; e_iw = 1; e_if = 0; e_xf = 0;
      end else if (phase == 0) begin
        if (ex_redirect)     begin e_pw = 1; e_iw = 1; e_if = 1; e_xf = 1; end
        else if (model_lu()) begin e_pw = 0; e_iw = 0; e_if = 0; e_xf = 1; end
        else if (id_halt)    begin e_pw = 0; e_iw = 0; e_if = 0; e_xf = 0; end
        else                 begin e_pw = 1; e_iw = 1; e_if = 0; e_xf = 0; end
      end else if (phase < 4) begin
        e_pw = 0; e_iw = 0; e_if = 1; e_xf = 0;
      end else begin
        e_pw = 0; e_iw = 0; e_if = 1; e_xf = 1; e_h = 1;
      end
      check("m_pc_write", pc_write, e_pw);
      check("m_ifid_write", ifid_write, e_iw);
      check("m_ifid_flush", ifid_flush, e_if);
      check("m_idex_flush", idex_flush, e_xf);
      check("m_halted", halted, e_h);
      check("m_fwd_a", fwd_a, model_fwd(ex_rs1));
      check("m_fwd_b", fwd_b, model_fwd(ex_rs2));
      check("m_stall_cnt", stall_cnt, m_stall);
      check("m_flush_cnt", flush_cnt, m_flush);
    end
  end

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_halt = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_mem_read = 0; ex_redirect = 0;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    // Writers targeting ex_rs1 during reset must not forward.
    mem_reg_write = 1; mem_rd = 3; ex_rs1 = 3;
    #2;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_pc_write", pc_write, 1);
    check("rst_halted", halted, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_fwd_a", fwd_a, 0);
    step();
    rst = 1'b0;
    idle();

    // Load-use: LW x5 in EX, ADD using x5 in ID.
    step();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    @(negedge clk);
    check("lu_pc_write", pc_write, 0);
    check("lu_idex_flush", idex_flush, 1);
    step();
    ex_mem_read = 0; mem_rd = 5; mem_reg_write = 1; ex_rs1 = 5;
    @(negedge clk);
    check("lu_after_pc_write", pc_write, 1);
    check("lu_stall_cnt", stall_cnt, 1);
    check("lu_after_fwd_a", fwd_a, 2);

    // Non-hazards: matching rs but unused, and a load to x0.
    step();
    idle();
    ex_mem_read = 1; ex_rd = 6; id_rs2 = 6; id_uses_rs2 = 0;
    step();
    ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
    @(negedge clk);
    check("x0_load_no_stall", pc_write, 1);

    // Redirect beats a simultaneous load-use.
    step();
    idle();
    ex_redirect = 1; ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    @(negedge clk);
    check("rd_ifid_flush", ifid_flush, 1);
    check("rd_idex_flush", idex_flush, 1);
    check("rd_pc_write", pc_write, 1);
    step();
    idle();
    @(negedge clk);
    check("rd_flush_cnt", flush_cnt, 1);
    check("rd_stall_cnt", stall_cnt, 1);

    // Forwarding priority.
    step();
    mem_rd = 7; wb_rd = 7; mem_reg_write = 1; wb_reg_write = 1; ex_rs1 = 7; ex_rs2 = 7;
    @(negedge clk);
    check("fwd_a_mem", fwd_a, 2);
    check("fwd_b_mem", fwd_b, 2);
    step();
    mem_reg_write = 0;
    @(negedge clk);
    check("fwd_a_wb", fwd_a, 1);
    step();
    ex_rs1 = 0; mem_rd = 0; wb_rd = 0; mem_reg_write = 1;
    @(negedge clk);
    check("fwd_a_x0", fwd_a, 0);
    step();
    ex_rs2 = 9; wb_rd = 9; mem_rd = 4;
    @(negedge clk);
    check("fwd_b_wb", fwd_b, 1);

    // Saturation: 20 consecutive load-use cycles on a 4-bit counter.
    step();
    idle();
    ex_mem_read = 1; ex_rd = 9; id_rs2 = 9; id_uses_rs2 = 1;
    for (int i = 0; i < 20; i++) step();
    idle();
    @(negedge clk);
    check("sat_stall_cnt", stall_cnt, 15);

    // Asynchronous reset while a load-use hazard is live.
    step();
    ex_mem_read = 1; ex_rd = 9; id_rs2 = 9; id_uses_rs2 = 1;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pc_write", pc_write, 1);
    check("arst_stall_cnt", stall_cnt, 0);
    check("arst_idex_flush", idex_flush, 0);
    step();
    rst = 1'b0;
    idle();

    // Halt: one decision cycle, three drain cycles, then frozen.
    step();
    id_halt = 1;
    @(negedge clk);
    check("halt_pc_write", pc_write, 0);
    check("halt_ifid_flush", ifid_flush, 0);
    check("halt_halted", halted, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      id_halt = 0;
      ex_redirect = (i == 1);
      @(negedge clk);
      check("drain_ifid_flush", ifid_flush, 1);
      check("drain_halted", halted, 0);
    end
    step();
    ex_redirect = 0;
    ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_uses_rs1 = 1;
    @(negedge clk);
    check("halted_flush_cnt", flush_cnt, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("halted_hold", halted, 1);
      step();
    end
    check("halted_stall_cnt", stall_cnt, 0);
    rst = 1'b1;
    #1;
    check("unhalt_halted", halted, 0);
    check("unhalt_pc_write", pc_write, 1);
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("run_pc_write", pc_write, 1);
    step();
    step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
